crossbar_row_buffer: RTL and testbench

//   Parametrised successor to the single crossbar register: a ROWS-deep buffer of N-bit

---
 rtl/crossbar_row_buffer.sv | 140 ++++++++++++++
 tb/tb_crossbar_row_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_row_buffer.sv
// ROWS-deep buffer of N-bit crossbar row words: filled through a valid/ready write port,
// then streamed in order to the PIM array through a valid/ready read port.
module crossbar_row_buffer #(
    parameter int unsigned N    = 10,
    parameter int unsigned ROWS = 8,
    localparam int unsigned AW  = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_valid,
    input  logic [N-1:0]  D,
    output logic          wr_ready,
    input  logic          PIM_start,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [N-1:0]  Q,
    output logic [AW-1:0] rd_row,
    output logic [AW-1:0] count,
    output logic          full,
    output logic          busy
);

    localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] rd_row_q, rd_row_d;
    logic [N-1:0]  q_q, q_d;
    logic          rd_valid_q, rd_valid_d;
    logic          mem_we;
    logic [N-1:0]  mem_q [ROWS];

    logic          wr_acc;
    logic [AW-1:0] count_inc;
    logic [AW-1:0] rd_row_inc;

    assign wr_ready   = (state_q == S_LOAD) && !clear;
    assign wr_acc     = wr_valid && wr_ready;
    assign count_inc  = count_q + AW'(1);
    assign rd_row_inc = rd_row_q + AW'(1);

    // Next-state, pointer and output-word selection
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_row_d   = rd_row_q;
        q_d        = q_q;
        rd_valid_d = rd_valid_q;
        mem_we     = 1'b0;

        if (clear) begin
            state_d    = S_LOAD;
            count_d    = '0;
            rd_row_d   = '0;
            rd_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (wr_acc) begin
                        mem_we  = 1'b1;
                        count_d = count_inc;
                    end
                    if (PIM_start && (wr_acc || (count_q != '0))) begin
                        // A first row written in the start cycle is not yet in memory
                        state_d    = S_DRAIN;
                        rd_valid_d = 1'b1;
                        rd_row_d   = '0;
                        q_d        = (count_q == '0) ? D : mem_q[0];
                    end else if (wr_acc && (count_inc == AW'(ROWS))) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (PIM_start) begin
                        state_d    = S_DRAIN;
                        rd_valid_d = 1'b1;
                        rd_row_d   = '0;
                        q_d        = mem_q[0];
                    end
                end
                S_DRAIN: begin
                    if (rd_valid_q && rd_ready) begin
                        if (rd_row_inc < count_q) begin
                            rd_row_d = rd_row_inc;
                            q_d      = mem_q[IW'(rd_row_inc)];
                        end else begin
                            state_d    = S_LOAD;
                            rd_valid_d = 1'b0;
                            count_d    = '0;
                            rd_row_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            count_q    <= '0;
            rd_row_q   <= '0;
            q_q        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_row_q   <= rd_row_d;
            q_q        <= q_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Row storage; the write pointer is the row count itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ROWS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[IW'(count_q)] <= D;
        end
    end

    assign rd_valid = rd_valid_q;
    assign Q        = q_q;
    assign rd_row   = rd_row_q;
    assign count    = count_q;
    assign full     = (count_q == AW'(ROWS));
    assign busy     = (state_q == S_DRAIN);

endmodule

// File: tb/tb_crossbar_row_buffer.sv
// Bench for crossbar_row_buffer (ROWS=4): directed scenarios then random traffic, checked
// every cycle against a queue-based frame model.
module tb_crossbar_row_buffer;

    localparam int unsigned N    = 10;
    localparam int unsigned ROWS = 4;
    localparam int unsigned AW   = $clog2(ROWS + 1);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          wr_valid;
    logic [N-1:0]  D;
    logic          wr_ready;
    logic          PIM_start;
    logic          rd_valid;
    logic          rd_ready;
    logic [N-1:0]  Q;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] count;
    logic          full;
    logic          busy;

    int errors = 0;
    int checks = 0;

    crossbar_row_buffer #(.N(N), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .D(D), .wr_ready(wr_ready),
        .PIM_start(PIM_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .Q(Q), .rd_row(rd_row), .count(count), .full(full), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the frame is a queue of stored words; mode 0=load 1=ready 2=drain
    int           m_mode;
    logic [N-1:0] m_frame[$];
    int           m_idx;
    logic         m_rdv;
    logic [N-1:0] m_q;
    logic [N-1:0] got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_frame.delete();
        m_idx  = 0;
        m_rdv  = 1'b0;
        m_q    = '0;
    endtask

    task automatic model_step(input logic cv, input logic wv, input logic [N-1:0] d,
                              input logic st, input logic rr);
        if (cv) begin
            m_mode = 0;
            m_frame.delete();
            m_rdv  = 1'b0;
            m_idx  = 0;
        end else if (m_mode == 0) begin
            if (wv) m_frame.push_back(d);
            if (st && m_frame.size() > 0) begin
                m_mode = 2; m_rdv = 1'b1; m_idx = 0; m_q = m_frame[0];
            end else if (m_frame.size() == int'(ROWS)) begin
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (st) begin
                m_mode = 2; m_rdv = 1'b1; m_idx = 0; m_q = m_frame[0];
            end
        end else if (rr) begin
            if (m_idx < m_frame.size() - 1) begin
                m_idx++;
                m_q = m_frame[m_idx];
            end else begin
                m_rdv = 1'b0; m_mode = 0; m_idx = 0;
                m_frame.delete();
            end
        end
    endtask

    task automatic check_outputs();
        chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
        chk("Q",        32'(Q),        32'(m_q));
        chk("rd_row",   32'(rd_row),   32'(m_idx));
        chk("count",    32'(count),    32'(m_frame.size()));
        chk("full",     32'(full),     32'(m_frame.size() == int'(ROWS)));
        chk("busy",     32'(busy),     32'(m_mode == 2));
        chk("wr_ready", 32'(wr_ready), 32'(m_mode == 0 && !clear));
    endtask

    // One clock: drive at the falling edge, check, then advance the model past the next rise
    task automatic cycle(input logic cv, input logic wv, input logic [N-1:0] d,
                         input logic st, input logic rr);
        @(negedge clk);
        clear = cv; wr_valid = wv; D = d; PIM_start = st; rd_ready = rr;
        #1;
        check_outputs();
        if (!cv && rd_valid && rr) got.push_back(Q);
        model_step(cv, wv, d, st, rr);
    endtask

    task automatic write_row(input logic [N-1:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, rr);
    endtask

    task automatic check_got(input string tag, input logic [N-1:0] e0, input logic [N-1:0] e1,
                             input logic [N-1:0] e2, input logic [N-1:0] e3, input int n);
        logic [N-1:0] exp_w [4];
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
        chk({tag, "_beats"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_word"}, 32'(got[i]), 32'(exp_w[i]));
        got.delete();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; D = '0; PIM_start = 1'b0; rd_ready = 1'b0;
        model_reset();
        #12;
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_count",    32'(count),    32'd0);
        chk("reset_Q",        32'(Q),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame, ignored extra write, full-speed drain
        for (int i = 1; i <= 4; i++) write_row(N'(i));
        write_row(10'h005);
        chk("t1_full", 32'(full), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(5, 1'b1);
        check_got("t1", 10'h001, 10'h002, 10'h003, 10'h004, 4);

        // Backpressure pattern 1,0,0,1
        for (int i = 1; i <= 4; i++) write_row(N'(i));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0, 1'b0, (i % 4 == 0) || (i % 4 == 3));
        check_got("t2", 10'h001, 10'h002, 10'h003, 10'h004, 4);

        // Partial frame, then start with an empty frame
        write_row(10'h0AA);
        write_row(10'h155);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(3, 1'b1);
        check_got("t3", 10'h0AA, 10'h155, 10'h000, 10'h000, 2);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("t3_empty_start_busy", 32'(busy), 32'd0);

        // Write and start in the same cycle
        write_row(10'h011);
        write_row(10'h022);
        cycle(1'b0, 1'b1, 10'h3FF, 1'b1, 1'b1);
        idle(4, 1'b1);
        check_got("t4", 10'h011, 10'h022, 10'h3FF, 10'h000, 3);

        // Start with the first row written in the same cycle
        cycle(1'b0, 1'b1, 10'h2C3, 1'b1, 1'b1);
        idle(2, 1'b1);
        check_got("t4b", 10'h2C3, 10'h000, 10'h000, 10'h000, 1);

        // clear after the second beat, then a new frame
        for (int i = 0; i < 4; i++) write_row(N'(10'h101 + i));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);
        cycle(1'b1, 1'b1, 10'h3AB, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t5_rd_valid", 32'(rd_valid), 32'd0);
        chk("t5_count",    32'(count),    32'd0);
        chk("t5_wr_ready", 32'(wr_ready), 32'd1);
        check_got("t5a", 10'h101, 10'h102, 10'h000, 10'h000, 2);
        write_row(10'h1E1);
        write_row(10'h1E2);
        write_row(10'h1E3);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(4, 1'b1);
        check_got("t5b", 10'h1E1, 10'h1E2, 10'h1E3, 10'h000, 3);

        // Asynchronous reset in the middle of a drain
        write_row(10'h0F0);
        write_row(10'h0F1);
        write_row(10'h0F2);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_Q",        32'(Q),        32'd0);
        chk("t6_count",    32'(count),    32'd0);
        model_reset();
        got.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        idle(1, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  $urandom_range(0, 1) == 1,
                  N'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) < 7));
        end
        got.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
